product_accumulator: RTL and testbench

- Downstream stage of the signed multiplier. Consumes its registered two's-complement product and sums a fixed number of consecutive products (a dot product of N_TERMS terms).
- Presents each completed sum on a valid/ready output register.
- in_valid is the multiplier's data_valid delayed by one clock, so it lines up with the multiplier's registered product.
- Supports backpressure and a synchronous abort of a partial sum.

---
 rtl/product_accumulator.sv | 133 +++++++++++++
 tb/tb_product_accumulator.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/product_accumulator.sv
// Sums N_TERMS consecutive signed products and presents each sum on a valid/ready output register.
// Build option ACC_SATURATE_EN: overflowing adds clamp to the signed limits instead of wrapping.
module product_accumulator #(
  parameter int WIDTH_IN  = 18,
  parameter int N_TERMS   = 8,
  parameter int WIDTH_ACC = 24
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  input  logic [WIDTH_IN-1:0]  in_product,
  output logic                 in_ready,
  input  logic                 clear,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH_ACC-1:0] out_sum,
  output logic                 out_ovf,
  output logic                 busy
);

  localparam int CNT_W = $clog2(N_TERMS);
  localparam logic [CNT_W-1:0]     LAST_CNT = CNT_W'(N_TERMS - 1);
  localparam logic [WIDTH_ACC-1:0] ACC_MAX  = {1'b0, {(WIDTH_ACC-1){1'b1}}};
  localparam logic [WIDTH_ACC-1:0] ACC_MIN  = {1'b1, {(WIDTH_ACC-1){1'b0}}};

  // Signed overflow: operands share a sign and the result sign differs.
  function automatic logic add_overflows(input logic [WIDTH_ACC-1:0] a,
                                         input logic [WIDTH_ACC-1:0] b,
                                         input logic [WIDTH_ACC-1:0] s);
    return (a[WIDTH_ACC-1] == b[WIDTH_ACC-1]) && (s[WIDTH_ACC-1] != a[WIDTH_ACC-1]);
  endfunction

  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [WIDTH_ACC-1:0] acc_q, acc_d;
  logic                 ovf_acc_q, ovf_acc_d;
  logic                 out_valid_q, out_valid_d;
  logic [WIDTH_ACC-1:0] out_sum_q, out_sum_d;
  logic                 out_ovf_q, out_ovf_d;

  logic [WIDTH_ACC-1:0] term_s, raw_sum_s, add_sum_s;
  logic                 add_ovf_s, last_s, accept_s;

  assign term_s    = WIDTH_ACC'($signed(in_product));
  assign raw_sum_s = acc_q + term_s;
  assign add_ovf_s = add_overflows(acc_q, term_s, raw_sum_s);
  assign last_s    = (cnt_q == LAST_CNT);

  // Only the final term can stall: it must not overwrite a result still waiting for the consumer.
  assign in_ready  = !clear && !(last_s && out_valid_q && !out_ready);
  assign accept_s  = in_valid && in_ready;

  // Adder result after the overflow policy of this build.
  always_comb begin
    add_sum_s = raw_sum_s;
`ifdef ACC_SATURATE_EN
    if (add_ovf_s) begin
      add_sum_s = acc_q[WIDTH_ACC-1] ? ACC_MIN : ACC_MAX;
    end else begin
      add_sum_s = raw_sum_s;
    end
`else
    add_sum_s = raw_sum_s;
`endif
  end

  // Next-state for the partial sum and the output register.
  always_comb begin
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    ovf_acc_d   = ovf_acc_q;
    out_valid_d = out_valid_q;
    out_sum_d   = out_sum_q;
    out_ovf_d   = out_ovf_q;

    if (clear) begin
      cnt_d     = '0;
      acc_d     = '0;
      ovf_acc_d = 1'b0;
    end else if (accept_s) begin
      if (cnt_q == '0) begin
        acc_d     = term_s;
        ovf_acc_d = 1'b0;
        cnt_d     = CNT_W'(1);
      end else if (last_s) begin
        acc_d     = '0;
        ovf_acc_d = 1'b0;
        cnt_d     = '0;
      end else begin
        acc_d     = add_sum_s;
        ovf_acc_d = ovf_acc_q | add_ovf_s;
        cnt_d     = cnt_q + CNT_W'(1);
      end
    end else begin
      cnt_d = cnt_q;
    end

    // A final term arriving on the consumer handshake reloads the register and keeps it valid.
    if (accept_s && last_s) begin
      out_valid_d = 1'b1;
      out_sum_d   = add_sum_s;
      out_ovf_d   = ovf_acc_q | add_ovf_s;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q       <= '0;
      acc_q       <= '0;
      ovf_acc_q   <= 1'b0;
      out_valid_q <= 1'b0;
      out_sum_q   <= '0;
      out_ovf_q   <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      ovf_acc_q   <= ovf_acc_d;
      out_valid_q <= out_valid_d;
      out_sum_q   <= out_sum_d;
      out_ovf_q   <= out_ovf_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_sum   = out_sum_q;
  assign out_ovf   = out_ovf_q;
  assign busy      = (cnt_q != '0);

endmodule

// File: tb/tb_product_accumulator.sv
// Self-checking bench: instance a (N_TERMS=4, 18->24 bit) and instance b (N_TERMS=2, 18->18 bit)
// against a block-level arithmetic reference model; directed plan cases then random traffic.
module tb_product_accumulator;

  logic        clk;
  logic        rst_n;
  logic        in_valid[2];
  logic        clear[2];
  logic        out_ready[2];
  logic [17:0] in_product[2];
  logic        in_ready[2];
  logic        out_valid[2];
  logic        out_ovf[2];
  logic        busy[2];
  logic [23:0] out_sum_a;
  logic [17:0] out_sum_b;

  int     drv_p[2];
  int     n_checks;
  int     n_errors;

  int     m_blk[2][$];
  bit     m_valid[2];
  longint m_sum[2];
  bit     m_ovf[2];

  product_accumulator #(.WIDTH_IN(18), .N_TERMS(4), .WIDTH_ACC(24)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_product(in_product[0]),
    .in_ready(in_ready[0]), .clear(clear[0]), .out_valid(out_valid[0]),
    .out_ready(out_ready[0]), .out_sum(out_sum_a), .out_ovf(out_ovf[0]), .busy(busy[0])
  );

  product_accumulator #(.WIDTH_IN(18), .N_TERMS(2), .WIDTH_ACC(18)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_product(in_product[1]),
    .in_ready(in_ready[1]), .clear(clear[1]), .out_valid(out_valid[1]),
    .out_ready(out_ready[1]), .out_sum(out_sum_b), .out_ovf(out_ovf[1]), .busy(busy[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int nt(input int i);
    return (i == 0) ? 4 : 2;
  endfunction

  function automatic int wa(input int i);
    return (i == 0) ? 24 : 18;
  endfunction

  function automatic string nm(input int i);
    return (i == 0) ? "a" : "b";
  endfunction

  task automatic check_val(input string tag, input logic signed [63:0] act,
                           input logic signed [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // Reference: sum the block's terms in order with unbounded integers, applying the range rule per add.
  function automatic void close_block(input int i);
    longint hi, lo, acc, t;
    bit     ovf;
    hi  = (longint'(1) <<< (wa(i) - 1)) - 1;
    lo  = -(longint'(1) <<< (wa(i) - 1));
    acc = 0;
    ovf = 1'b0;
    for (int k = 0; k < m_blk[i].size(); k++) begin
      t = acc + m_blk[i][k];
      if (t > hi || t < lo) begin
        ovf = 1'b1;
`ifdef ACC_SATURATE_EN
        t = (t > hi) ? hi : lo;
`else
        t = (t > hi) ? t - (hi - lo + 1) : t + (hi - lo + 1);
`endif
      end
      acc = t;
    end
    m_sum[i]   = acc;
    m_ovf[i]   = ovf;
    m_valid[i] = 1'b1;
    m_blk[i].delete();
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 2; i++) begin
      m_blk[i].delete();
      m_valid[i] = 1'b0;
      m_sum[i]   = 0;
      m_ovf[i]   = 1'b0;
    end
  endfunction

  task automatic check_outputs();
    for (int i = 0; i < 2; i++) begin
      check_val($sformatf("%s.out_valid", nm(i)), out_valid[i], m_valid[i]);
      check_val($sformatf("%s.out_ovf", nm(i)), out_ovf[i], m_ovf[i]);
      check_val($sformatf("%s.busy", nm(i)), busy[i], m_blk[i].size() != 0);
    end
    check_val("a.out_sum", $signed(out_sum_a), m_sum[0]);
    check_val("b.out_sum", $signed(out_sum_b), m_sum[1]);
  endtask

  // One clock: inputs already set at the falling edge; check in_ready, advance model, check outputs.
  task automatic tick();
    bit rdy, fire;
    for (int i = 0; i < 2; i++) in_product[i] = drv_p[i][17:0];
    #1;
    for (int i = 0; i < 2; i++) begin
      rdy  = !clear[i] && !((m_blk[i].size() == nt(i) - 1) && m_valid[i] && !out_ready[i]);
      check_val($sformatf("%s.in_ready", nm(i)), in_ready[i], rdy);
      fire = in_valid[i] && rdy;
      if (clear[i]) m_blk[i].delete();
      else if (fire) m_blk[i].push_back(drv_p[i]);
      if (fire && m_blk[i].size() == nt(i)) close_block(i);
      else if (m_valid[i] && out_ready[i]) m_valid[i] = 1'b0;
    end
    @(posedge clk);
    @(negedge clk);
    check_outputs();
  endtask

  task automatic set_in(input int i, input bit v, input int p, input bit c, input bit r);
    in_valid[i]  = v;
    drv_p[i]     = p;
    clear[i]     = c;
    out_ready[i] = r;
  endtask

  task automatic drive_a(input bit v, input int p, input bit c, input bit r);
    set_in(0, v, p, c, r);
    set_in(1, 1'b0, 0, 1'b0, 1'b1);
    tick();
  endtask

  task automatic drive_b(input bit v, input int p, input bit c, input bit r);
    set_in(0, 1'b0, 0, 1'b0, 1'b1);
    set_in(1, v, p, c, r);
    tick();
  endtask

  initial begin
    logic signed [17:0] r18;
    n_checks = 0;
    n_errors = 0;
    rst_n    = 1'b0;
    for (int i = 0; i < 2; i++) set_in(i, 1'b0, 0, 1'b0, 1'b1);
    for (int i = 0; i < 2; i++) in_product[i] = 18'd0;
    model_reset();
    repeat (2) @(negedge clk);
    check_outputs();
    rst_n = 1'b1;

    // Basic sum: 100 - 30 + 7 - 200 = -123
    drive_a(1'b1, 100, 1'b0, 1'b1);
    drive_a(1'b1, -30, 1'b0, 1'b1);
    drive_a(1'b1, 7, 1'b0, 1'b1);
    drive_a(1'b1, -200, 1'b0, 1'b1);
    check_val("basic.valid", out_valid[0], 1);
    check_val("basic.sum", $signed(out_sum_a), -123);
    check_val("basic.ovf", out_ovf[0], 0);
    drive_a(1'b0, 0, 1'b0, 1'b1);
    check_val("basic.pulse", out_valid[0], 0);

    // Backpressure: first result held, second block stalls on its final term until consumed
    for (int k = 0; k < 8; k++) begin
      drive_a(1'b1, 1, 1'b0, 1'b0);
      if (k == 3) check_val("bp.first", $signed(out_sum_a), 4);
    end
    check_val("bp.held", out_valid[0], 1);
    check_val("bp.busy", busy[0], 1);
    drive_a(1'b1, 1, 1'b0, 1'b1);
    check_val("bp.second_valid", out_valid[0], 1);
    check_val("bp.second_sum", $signed(out_sum_a), 4);
    check_val("bp.idle", busy[0], 0);
    drive_a(1'b0, 0, 1'b0, 1'b1);

    // Clear aborts a partial sum
    drive_a(1'b1, 50, 1'b0, 1'b1);
    drive_a(1'b1, 60, 1'b0, 1'b1);
    drive_a(1'b1, 99, 1'b1, 1'b1);
    check_val("clr.busy", busy[0], 0);
    for (int k = 1; k <= 4; k++) drive_a(1'b1, k, 1'b0, 1'b1);
    check_val("clr.sum", $signed(out_sum_a), 10);

    // Overflow on the 18-bit instance
    drive_b(1'b1, 131071, 1'b0, 1'b1);
    drive_b(1'b1, 1, 1'b0, 1'b1);
`ifdef ACC_SATURATE_EN
    check_val("ovf.sum", $signed(out_sum_b), 131071);
`else
    check_val("ovf.sum", $signed(out_sum_b), -131072);
`endif
    check_val("ovf.flag", out_ovf[1], 1);
    drive_b(1'b1, 5, 1'b0, 1'b1);
    drive_b(1'b1, 6, 1'b0, 1'b1);
    check_val("ovf.next_sum", $signed(out_sum_b), 11);
    check_val("ovf.next_flag", out_ovf[1], 0);

    // Asynchronous reset mid-block
    for (int k = 0; k < 3; k++) drive_a(1'b1, 3, 1'b0, 1'b1);
    rst_n = 1'b0;
    #1;
    model_reset();
    check_outputs();
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) drive_a(1'b1, 1, 1'b0, 1'b1);
    check_val("rst.sum", $signed(out_sum_a), 4);

    // Throughput: 1..12 back to back
    for (int k = 1; k <= 12; k++) begin
      drive_a(1'b1, k, 1'b0, 1'b1);
      if (k % 4 == 0) check_val("thr.sum", $signed(out_sum_a), 16 * (k / 4 - 1) + 10);
    end
    drive_a(1'b0, 0, 1'b0, 1'b1);

    // Random traffic on both instances
    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < 2; i++) begin
        r18 = 18'($urandom);
        set_in(i, $urandom_range(0, 3) != 0, int'(r18), $urandom_range(0, 15) == 0,
               $urandom_range(0, 1) == 1);
      end
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
